// File: rtl/alu4_seq.sv
// -----------------------------------------------------------------------------
// alu4_seq
//   Accumulator-based command sequencer wrapped around the combinational 4-bit
//   ALU (alu4). One command is accepted per handshake, its operand and select
//   are registered onto the ALU inputs for a single EXEC cycle, the ALU result
//   is captured, and it is returned on a valid/ready response port.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready decodes state only)
//   cmd_load            1 = load accumulator with cmd_data, 0 = ALU op
//   cmd_op[2:0]         ALU select code
//   cmd_data[3:0]       operand y, or load value
//   alu_x/y/s           registered ALU inputs (x is the accumulator)
//   alu_r[3:0]          combinational ALU result
//   rsp_valid/ready     response handshake (valid decodes state only)
//   rsp_data[3:0]       captured result
//   rsp_flag            compare result, 0 for non-compare commands
//   acc[3:0]            current accumulator
//   op_cnt[7:0]         completed responses, wraps 255 -> 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready = 1
// EXEC  | ALU inputs stable for one cycle; result captured at cycle end
// RESP  | response presented; rsp_valid = 1 until rsp_ready
// -----------------------------------------------------------------------------
module alu4_seq #(
    parameter logic [3:0] ACC_INIT = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] alu_x,
    output logic [3:0] alu_y,
    output logic [2:0] alu_s,
    input  logic [3:0] alu_r,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_flag,
    output logic [3:0] acc,
    output logic [7:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   load_q;
    logic   cmd_fire;
    logic   rsp_fire;
    logic   is_cmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        cmd_fire  = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                cmd_fire  = cmd_valid;
                if (cmd_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_fire  = rsp_ready;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // less (110) and equal (111) report through the flag and leave acc alone
    assign is_cmp = (alu_s[2:1] == 2'b11);
    assign alu_x  = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q   <= 1'b0;
            alu_y    <= 4'h0;
            alu_s    <= 3'b000;
            acc      <= ACC_INIT;
            rsp_data <= 4'h0;
            rsp_flag <= 1'b0;
            op_cnt   <= 8'h00;
        end else begin
            if (cmd_fire) begin
                load_q <= cmd_load;
                alu_y  <= cmd_data;
                alu_s  <= cmd_op;
            end
            if (state == EXEC) begin
                if (load_q) begin
                    acc      <= alu_y;
                    rsp_data <= alu_y;
                    rsp_flag <= 1'b0;
                end else if (is_cmp) begin
                    rsp_data <= alu_r;
                    rsp_flag <= alu_r[0];
                end else begin
                    acc      <= alu_r;
                    rsp_data <= alu_r;
                    rsp_flag <= 1'b0;
                end
            end
            if (rsp_fire) begin
                op_cnt <= op_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu4_seq.sv
module tb_alu4_seq;

    localparam logic [3:0] INIT = 4'h5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [2:0] cmd_op = 3'b000;
    logic [3:0] cmd_data = 4'h0;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic [2:0] alu_s;
    logic [3:0] alu_r;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_flag;
    logic [3:0] acc;
    logic [7:0] op_cnt;

    int vecs = 0;
    int errs = 0;

    alu4_seq #(.ACC_INIT(INIT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_r(alu_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .acc(acc), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // stand-in for the combinational alu4
    always_comb begin
        alu_r = 4'h0;
        case (alu_s)
            3'b000: alu_r = alu_x + alu_y;
            3'b001: alu_r = alu_x - alu_y;
            3'b010: alu_r = ~alu_x;
            3'b011: alu_r = alu_x & alu_y;
            3'b100: alu_r = alu_x | alu_y;
            3'b101: alu_r = alu_x ^ alu_y;
            3'b110: alu_r = {3'b000, ($signed(alu_x) < $signed(alu_y))};
            3'b111: alu_r = {3'b000, (alu_x == alu_y)};
            default: alu_r = 4'h0;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string tag, input logic ld, input logic [2:0] op,
                          input logic [3:0] d, input logic [3:0] exp_data,
                          input logic exp_flag, input logic [3:0] exp_acc);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = d;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_exec_y"}, {12'h0, alu_y}, {12'h0, d});
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {15'h0, rsp_valid}, 16'h1);
        check({tag, "_data"}, {12'h0, rsp_data}, {12'h0, exp_data});
        check({tag, "_flag"}, {15'h0, rsp_flag}, {15'h0, exp_flag});
        @(negedge clk);
        check({tag, "_acc"}, {12'h0, acc}, {12'h0, exp_acc});
        check({tag, "_ready"}, {15'h0, cmd_ready}, 16'h1);
    endtask

    initial begin
        int cyc;
        int last;
        int k;
        logic seen;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_acc", {12'h0, acc}, {12'h0, INIT});
        check("rst_alu_x", {12'h0, alu_x}, {12'h0, INIT});
        check("rst_alu_y", {12'h0, alu_y}, 16'h0);
        check("rst_alu_s", {13'h0, alu_s}, 16'h0);
        check("rst_rsp_valid", {15'h0, rsp_valid}, 16'h0);
        check("rst_rsp_data", {12'h0, rsp_data}, 16'h0);
        check("rst_op_cnt", {8'h0, op_cnt}, 16'h0);
        check("rst_cmd_ready", {15'h0, cmd_ready}, 16'h1);
        rst = 1'b0;

        // load/add
        do_cmd("ld7",  1'b1, 3'b000, 4'h7, 4'h7, 1'b0, 4'h7);
        do_cmd("add5", 1'b0, 3'b000, 4'h5, 4'hC, 1'b0, 4'hC);
        check("cnt2", {8'h0, op_cnt}, 16'h2);
        // wrap and subtract
        do_cmd("ldF",  1'b1, 3'b000, 4'hF, 4'hF, 1'b0, 4'hF);
        do_cmd("add1", 1'b0, 3'b000, 4'h1, 4'h0, 1'b0, 4'h0);
        do_cmd("ld3",  1'b1, 3'b000, 4'h3, 4'h3, 1'b0, 4'h3);
        do_cmd("sub5", 1'b0, 3'b001, 4'h5, 4'hE, 1'b0, 4'hE);
        // compares leave acc unchanged
        do_cmd("ld8",  1'b1, 3'b000, 4'h8, 4'h8, 1'b0, 4'h8);
        do_cmd("lt1",  1'b0, 3'b110, 4'h1, 4'h1, 1'b1, 4'h8);
        do_cmd("eq8",  1'b0, 3'b111, 4'h8, 4'h1, 1'b1, 4'h8);
        do_cmd("eq7",  1'b0, 3'b111, 4'h7, 4'h0, 1'b0, 4'h8);
        // logic ops
        do_cmd("ldA",  1'b1, 3'b000, 4'hA, 4'hA, 1'b0, 4'hA);
        do_cmd("and6", 1'b0, 3'b011, 4'h6, 4'h2, 1'b0, 4'h2);
        do_cmd("or5",  1'b0, 3'b100, 4'h5, 4'h7, 1'b0, 4'h7);
        do_cmd("xorF", 1'b0, 3'b101, 4'hF, 4'h8, 1'b0, 4'h8);
        do_cmd("not",  1'b0, 3'b010, 4'h0, 4'h7, 1'b0, 4'h7);
        check("cnt15", {8'h0, op_cnt}, 16'd15);

        // backpressure: add 1 to 7, cmd_valid kept high with a different load
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 4'h1;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_load = 1'b1;
        cmd_data = 4'h9;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {15'h0, rsp_valid}, 16'h1);
            check("bp_data", {12'h0, rsp_data}, 16'h8);
            check("bp_flag", {15'h0, rsp_flag}, 16'h0);
            check("bp_ready", {15'h0, cmd_ready}, 16'h0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_acc", {12'h0, acc}, 16'h8);
        check("bp_cnt", {8'h0, op_cnt}, 16'd16);
        @(negedge clk);
        check("bp_no_second", {15'h0, cmd_ready}, 16'h1);

        // reset during EXEC of add 3 with acc = 4
        do_cmd("ld4", 1'b1, 3'b000, 4'h4, 4'h4, 1'b0, 4'h4);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 4'h3;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_y", {12'h0, alu_y}, 16'h3);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_acc", {12'h0, acc}, {12'h0, INIT});
        check("mid_rst_cnt", {8'h0, op_cnt}, 16'h0);
        check("mid_rst_valid", {15'h0, rsp_valid}, 16'h0);
        check("mid_rst_y", {12'h0, alu_y}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {15'h0, cmd_ready}, 16'h1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("post_rst_no_rsp", {15'h0, seen}, 16'h0);
        check("post_rst_acc", {12'h0, acc}, {12'h0, INIT});

        // 256 back-to-back adds of 1 from INIT
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 4'h1;
        rsp_ready = 1'b1;
        cyc = 0;
        last = 0;
        k = 0;
        while (k < 256 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                k++;
                check("b2b_data", {12'h0, rsp_data}, 16'((5 + k) & 15));
                if (k > 1) check("b2b_gap", 16'(cyc - last), 16'd3);
                last = cyc;
                if (k == 256) begin
                    check("b2b_cnt255", {8'h0, op_cnt}, 16'd255);
                    cmd_valid = 1'b0;
                end
            end
        end
        check("b2b_count", 16'(k), 16'd256);
        @(negedge clk);
        check("b2b_wrap", {8'h0, op_cnt}, 16'h0);
        check("b2b_idle", {15'h0, cmd_ready}, 16'h1);
        @(negedge clk);
        check("b2b_no_extra", {15'h0, cmd_ready}, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/alu4_seq.md
# alu4_seq

Accumulator-based command sequencer that sits directly upstream of the 4-bit ALU (`alu4`) and drives its operand and select inputs. It accepts one command per handshake, presents the accumulator and command operand to the ALU for one cycle, and captures the ALU result. It writes the result back to the accumulator and returns it on a valid/ready response port. It turns the purely combinational ALU into a handshaked, stateful datapath for the NPC test harness.

## Interface
Parameters:
- `ACC_INIT`, default 4'b0000: accumulator value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_load`  in  1  1 = load accumulator with `cmd_data`; 0 = ALU operation.
- `cmd_op`  in  3  ALU select code (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 less, 111 equal).
- `cmd_data`  in  4  operand y (or load value).
- `alu_x`  out  4  to ALU `in_x`; always equals the accumulator.
- `alu_y`  out  4  to ALU `in_y`; latched `cmd_data`.
- `alu_s`  out  3  to ALU `in_s`; latched `cmd_op`.
- `alu_r`  in  4  from ALU `out_s`; combinational result.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  downstream accepts response.
- `rsp_data`  out  4  result value.
- `rsp_flag`  out  1  compare result; 0 for non-compare commands.
- `acc`  out  4  current accumulator.
- `op_cnt`  out  8  number of completed responses.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch `cmd_load`, `cmd_op` and `cmd_data` into registers, then go to EXEC.
- EXEC (exactly one cycle): `alu_x`/`alu_y`/`alu_s` are registered and stable for the whole cycle. At the cycle's end, capture as follows, then go to RESP:
  - load: `acc`←data, `rsp_data`←data, `rsp_flag`←0.
  - op 000–101: `acc`←`alu_r`, `rsp_data`←`alu_r`, `rsp_flag`←0.
  - op 110/111: `acc` unchanged, `rsp_data`←`alu_r`, `rsp_flag`←`alu_r[0]`.
- RESP:
  - `rsp_valid`=1.
  - On `rsp_ready`: go to IDLE and increment `op_cnt`, which is 8-bit and wraps 255→0.
- Arithmetic is 4-bit modulo 16. Signed interpretation (for less) is performed by the ALU; this block does not inspect or alter it.
- `cmd_ready` and `rsp_valid` decode state only; there is no combinational path from `cmd_valid` or `rsp_ready`.
- `cmd_valid` during EXEC or RESP is not accepted. The upstream holds fields stable until the handshake completes.
- `rsp_data` and `rsp_flag` hold stable while `rsp_valid`&&!`rsp_ready`.

## Timing
- Reset values:
  - state IDLE.
  - `acc`=`ACC_INIT`, so `alu_x`=`ACC_INIT`.
  - `alu_y`=0, `alu_s`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_flag`=0.
  - `op_cnt`=0, `cmd_ready`=1.
- A command accepted at edge n puts the block in EXEC during cycle n→n+1. The result is captured at edge n+1, and `rsp_valid`=1 from edge n+1.
- If `rsp_ready` is high in that cycle, the response completes at edge n+2, and `cmd_ready`=1 again after edge n+2.
- Maximum throughput is one command per 3 cycles.
- `rst` asserted at any time (including EXEC or RESP):
  - all registers reset immediately;
  - any in-flight command is dropped with no response;
  - `op_cnt` is not incremented.
- `rsp_ready` held high in IDLE/EXEC has no effect.

## Test plan
- Load 7, then add 5 → responses 4'h7 then 4'hC with flag 0; `acc`=4'hC; `op_cnt`=2.
- Load F, add 1 → `rsp_data`=4'h0 (wrap); load 3, sub 5 → `rsp_data`=4'hE, `acc`=4'hE.
- Load 8, less 1 → `rsp_flag`=1, `acc` stays 4'h8; then equal 8 → `rsp_flag`=1; then equal 7 → `rsp_flag`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with `cmd_valid` high → `rsp_data`/`rsp_flag` stable, `cmd_ready`=0 throughout, no second command accepted.
- Assert `rst` during EXEC of add 3 (acc=4) → `rsp_valid` never rises, `acc`=`ACC_INIT`, `op_cnt`=0, `cmd_ready`=1 next cycle.
- Issue 256 back-to-back commands with `rsp_ready`=1 → `op_cnt` reads 0 after the last, each response 3 cycles apart.
